// File: rtl/bcd_display_pkg.sv
// Shared types and 7-segment constants for the BCD display driver.
// Segments are active-low, bit0 = a .. bit6 = g.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_multi_display_if.sv
// Value request and display result bundle for bcd_multi_display.
interface bcd_multi_display_if #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned NUM_DIGITS = 4
);
    logic [WIDTH-1:0]        BIN;
    logic                    BIN_VALID;
    logic                    BIN_READY;
    logic [7*NUM_DIGITS-1:0] HEX;
    logic                    OVERFLOW;

    modport master (output BIN, BIN_VALID, input BIN_READY, HEX, OVERFLOW);
    modport slave  (input BIN, BIN_VALID, output BIN_READY, HEX, OVERFLOW);
endinterface

// File: rtl/bcd_multi_display_seg7_digit_decoder.sv
// One BCD nibble to active-low 7-segment pattern; non-decimal nibbles go blank.
module seg7_digit_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_multi_display.sv
// Sequential double-dabble binary-to-decimal converter driving a 7-segment bank.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the leading nonzero one.
module bcd_multi_display
    import bcd_display_pkg::*;
#(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    bcd_multi_display_if.slave  bus
);

    localparam int unsigned SW = 4 * NUM_DIGITS;
    localparam int unsigned HW = 7 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [SW-1:0]   scratch, scratch_nxt;
    logic            sticky, sticky_nxt;
    logic [HW-1:0]   hex_r, hex_nxt;
    logic            ovf_r, ovf_nxt;
    logic            ready_r, ready_nxt;

    logic [SW-1:0]   adj;
    logic [SW-1:0]   scratch_sh;
    logic [WIDTH-1:0] shreg_sh;
    logic            carry;
    logic [6:0]      dec_seg [NUM_DIGITS];
    logic [HW-1:0]   disp;

    // One double-dabble step: add-3 correction, then shift {scratch, shreg} left.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        carry      = adj[SW-1];
        scratch_sh = {adj[SW-2:0], shreg[WIDTH-1]};
        shreg_sh   = shreg << 1;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_digit_decoder u_dec (
            .bcd   (scratch[4*g +: 4]),
            .seg_c (dec_seg[g])
        );
    end

    // Display image presented to the output register in LOAD.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic seen;
        seen = 1'b0;
`endif
        disp = '1;
        for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (scratch[4*d +: 4] != 4'd0)
                seen = 1'b1;
            disp[7*d +: 7] = (seen || d == 0) ? dec_seg[d] : SEG_BLANK;
`else
            disp[7*d +: 7] = dec_seg[d];
`endif
        end
        if (sticky)
            disp = {NUM_DIGITS{SEG_DASH}};
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        scratch_nxt = scratch;
        sticky_nxt  = sticky;
        hex_nxt     = hex_r;
        ovf_nxt     = ovf_r;
        case (state)
            IDLE: begin
                if (bus.BIN_VALID) begin
                    shreg_nxt   = bus.BIN;
                    scratch_nxt = '0;
                    sticky_nxt  = 1'b0;
                    cnt_nxt     = CW'(WIDTH);
                    state_nxt   = CONVERT;
                end
            end
            CONVERT: begin
                shreg_nxt   = shreg_sh;
                scratch_nxt = scratch_sh;
                sticky_nxt  = sticky | carry;
                cnt_nxt     = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = LOAD;
            end
            LOAD: begin
                hex_nxt   = disp;
                ovf_nxt   = sticky;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            scratch <= '0;
            sticky  <= 1'b0;
            hex_r   <= '1;
            ovf_r   <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            scratch <= scratch_nxt;
            sticky  <= sticky_nxt;
            hex_r   <= hex_nxt;
            ovf_r   <= ovf_nxt;
            ready_r <= ready_nxt;
        end
    end

    assign bus.HEX       = hex_r;
    assign bus.OVERFLOW  = ovf_r;
    assign bus.BIN_READY = ready_r;

endmodule

// File: tb/tb_bcd_multi_display.sv
// Randomized self-checking bench: a 10-bit and a 16-bit instance against a decimal model.
module tb_bcd_multi_display;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [6:0] SEGT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    bcd_multi_display_if #(.WIDTH(10), .NUM_DIGITS(4)) ifa ();
    bcd_multi_display_if #(.WIDTH(16), .NUM_DIGITS(4)) ifb ();

    bcd_multi_display #(.WIDTH(10), .NUM_DIGITS(4)) dut_a (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (ifa.slave)
    );

    bcd_multi_display #(.WIDTH(16), .NUM_DIGITS(4)) dut_b (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Decimal reference: digits from division, leading-digit count from magnitude.
    function automatic logic [27:0] model_hex(input int v);
        logic [27:0] r;
        int sig, t, p;
        if (v > 9999) return {4{7'h3F}};
        sig = 1;
        t = v / 10;
        while (t > 0) begin sig++; t = t / 10; end
        r = '1;
        p = 1;
        for (int d = 0; d < 4; d++) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (d < sig) r[7*d +: 7] = SEGT[(v / p) % 10];
`else
            r[7*d +: 7] = SEGT[(v / p) % 10];
`endif
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] hex_of(input int sel);
        return (sel != 0) ? ifb.HEX : ifa.HEX;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel != 0) ? ifb.BIN_READY : ifa.BIN_READY;
    endfunction

    function automatic logic ovf_of(input int sel);
        return (sel != 0) ? ifb.OVERFLOW : ifa.OVERFLOW;
    endfunction

    task automatic set_in(input int sel, input int v, input logic valid);
        if (sel != 0) begin ifb.BIN = 16'(v); ifb.BIN_VALID = valid; end
        else          begin ifa.BIN = 10'(v); ifa.BIN_VALID = valid; end
    endtask

    // One request with a single-cycle valid; checks busy length, hold, result.
    task automatic run_conv(input int sel, input int v);
        int          lowcnt;
        logic [27:0] held;
        logic        held_ok;
        int          w;
        w = (sel != 0) ? 16 : 10;
        held = hex_of(sel);
        held_ok = 1'b1;
        check("ready_before", 32'(ready_of(sel)), 32'd1);
        set_in(sel, v, 1'b1);
        @(negedge clk);
        set_in(sel, int'($urandom), 1'b0);
        lowcnt = 0;
        while (ready_of(sel) == 1'b0 && lowcnt < 100) begin
            if (hex_of(sel) !== held) held_ok = 1'b0;
            lowcnt++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(lowcnt), 32'(w + 1));
        check("hold_busy", 32'(held_ok), 32'd1);
        check("hex", 32'(hex_of(sel)), 32'(model_hex(v)));
        check("overflow", 32'(ovf_of(sel)), 32'(v > 9999));
    endtask

    // BIN_VALID held high with BIN scrambled while busy: only accept-edge values count.
    task automatic stream_test();
        int v1, v2, lowcnt;
        check("stream_ready", 32'(ifa.BIN_READY), 32'd1);
        v1 = int'($urandom_range(1023));
        set_in(0, v1, 1'b1);
        @(negedge clk);
        lowcnt = 0;
        while (ifa.BIN_READY == 1'b0 && lowcnt < 100) begin
            set_in(0, int'($urandom), 1'b1);
            lowcnt++;
            @(negedge clk);
        end
        check("stream_busy1", 32'(lowcnt), 32'd11);
        check("stream_hex1", 32'(ifa.HEX), 32'(model_hex(v1)));
        v2 = int'($urandom_range(1023));
        set_in(0, v2, 1'b1);
        @(negedge clk);
        check("stream_accept2", 32'(ifa.BIN_READY), 32'd0);
        lowcnt = 0;
        while (ifa.BIN_READY == 1'b0 && lowcnt < 100) begin
            set_in(0, int'($urandom), 1'b1);
            lowcnt++;
            @(negedge clk);
        end
        set_in(0, 0, 1'b0);
        check("stream_busy2", 32'(lowcnt), 32'd11);
        check("stream_hex2", 32'(ifa.HEX), 32'(model_hex(v2)));
    endtask

    initial begin
        logic [27:0] held;
        logic        ok;
        set_in(0, 0, 1'b0);
        set_in(1, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_hex_a", 32'(ifa.HEX), 32'h0FFFFFFF);
        check("rst_ovf_a", 32'(ifa.OVERFLOW), 32'd0);
        check("rst_ready_a", 32'(ifa.BIN_READY), 32'd1);
        check("rst_hex_b", 32'(ifb.HEX), 32'h0FFFFFFF);
        check("rst_ready_b", 32'(ifb.BIN_READY), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_conv(0, 1023);
        run_conv(0, 0);
        run_conv(1, 12345);

        // Reset in the middle of a conversion discards it and clears both outputs.
        set_in(0, 500, 1'b1);
        @(negedge clk);
        set_in(0, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_before_rst", 32'(ifa.BIN_READY), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hex_a", 32'(ifa.HEX), 32'h0FFFFFFF);
        check("midrst_ovf_a", 32'(ifa.OVERFLOW), 32'd0);
        check("midrst_ready_a", 32'(ifa.BIN_READY), 32'd1);
        check("midrst_hex_b", 32'(ifb.HEX), 32'h0FFFFFFF);
        check("midrst_ovf_b", 32'(ifb.OVERFLOW), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_hold", 32'(ifa.HEX), 32'h0FFFFFFF);

        run_conv(1, 9999);
        run_conv(0, 47);

        held = ifa.HEX;
        ok = 1'b1;
        repeat (100) begin
            set_in(0, int'($urandom), 1'b0);
            @(negedge clk);
            if (ifa.HEX !== held || ifa.OVERFLOW !== 1'b0 || ifa.BIN_READY !== 1'b1) ok = 1'b0;
        end
        check("idle_hold_100", 32'(ok), 32'd1);
        check("idle_hold_val", 32'(ifa.HEX), 32'(model_hex(47)));

        stream_test();

        for (int i = 0; i < 8; i++) run_conv(0, int'($urandom_range(1023)));
        for (int i = 0; i < 8; i++) run_conv(1, int'($urandom_range(65535)));
        run_conv(1, 10000);
        run_conv(1, 65535);
        run_conv(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
